fifo_control: RTL and testbench
===============================

FIFO_CONTROL -- requirements
Module: fifo_control

Interface
REQ-001 SHALL provide parameter AF_LEVEL, default 6, AlmostFull threshold in entries (1..7).
REQ-002 SHALL provide parameter AE_LEVEL, default 2, AlmostEmpty threshold in entries (1..7).
REQ-003 SHALL have port Clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Push  input  1  producer requests a write of the current data word this cycle.
REQ-006 SHALL have port Pop  input  1  consumer takes the word presented on the memory read data this cycle.
REQ-007 SHALL have port Clear  input  1  synchronous flush of pointers, count and error flags.
REQ-008 SHALL have port AddrWrite  output  3  write address to the 8x16 FIFO memory.
REQ-009 SHALL have port AddrRead  output  3  read address to the 8x16 FIFO memory; read data is combinational from it.
REQ-010 SHALL have port WE  output  1  memory write enable, active high.
REQ-011 SHALL have port OE  output  1  memory read enable / pop accepted, active high.
REQ-012 SHALL have port Count  output  4  occupancy, 0..8.
REQ-013 SHALL have ports Full, Empty  output  1 each  occupancy status.
REQ-014 SHALL have ports Overflow, Underflow  output  1 each  sticky error flags.
REQ-015 SHALL have ports AlmostFull, AlmostEmpty  output  1 each  present only with FIFO_CONTROL_ALMOST_EN.

Function
REQ-016 SHALL hold 4-bit write and read pointers (3 address bits + wrap bit); AddrWrite/AddrRead = pointer bits [2:0].
REQ-017 SHALL drive Full = (Count==8) and Empty = (Count==0), decoded from registered state only.
REQ-018 SHALL drive WE = Push & (~Full | Pop) & ~Clear, combinationally, so the memory samples it at the same edge.
REQ-019 SHALL drive OE = Pop & ~Empty & ~Clear, combinationally; the data word at AddrRead is valid in the same cycle OE is high.
REQ-020 SHALL increment the write pointer (mod 16) on each edge where WE=1, and the read pointer on each edge where OE=1.
REQ-021 SHALL update Count: +1 if WE only, -1 if OE only, unchanged if both or neither.
REQ-022 Push+Pop when Full SHALL accept both; Count stays 8, both pointers advance.
REQ-023 Push+Pop when Empty SHALL accept only the push (no bypass); Count becomes 1.
REQ-024 Push with Full and no Pop SHALL be dropped (WE=0) and SHALL set Overflow at the next edge.
REQ-025 Pop with Empty SHALL be rejected (OE=0) and SHALL set Underflow at the next edge.
REQ-026 Overflow/Underflow SHALL remain set until Clear or Reset.
REQ-027 Clear SHALL take priority over Push/Pop: next edge pointers=0, Count=0, Overflow=Underflow=0; memory contents untouched.
REQ-028 Pointer wrap 15->0 SHALL be seamless; Full/Empty never derived from pointer comparison alone.

Reset
REQ-029 Reset high SHALL immediately force pointers=0, Count=0, Overflow=0, Underflow=0, giving AddrWrite=AddrRead=0, Empty=1, Full=0, AlmostEmpty=1, AlmostFull=0.
REQ-030 Reset asserted mid-operation SHALL discard all occupancy; first push after release writes address 0.
REQ-031 WE and OE SHALL be 0 while Reset is high regardless of Push/Pop.

Configuration
REQ-032 With FIFO_CONTROL_ALMOST_EN defined: AlmostFull = (Count >= AF_LEVEL), AlmostEmpty = (Count <= AE_LEVEL), both from registered Count.
REQ-033 Without FIFO_CONTROL_ALMOST_EN: AlmostFull/AlmostEmpty ports and logic SHALL be absent; all other behaviour identical.

Verification
REQ-034 Reset, then 8 pushes (no pop) -> AddrWrite 0..7 with WE=1, Count 1..8, Full=1 after 8th edge, Empty=0.
REQ-035 From Full, 9th push alone -> WE=0, Count=8, Overflow=1 next edge, stays 1 until Clear.
REQ-036 From Empty, pop alone -> OE=0, Underflow=1; then Push+Pop -> WE=1, OE=0, Count=1.
REQ-037 Fill 8, then 20 cycles Push+Pop -> Count=8 throughout, pointers wrap through 15->0, data order preserved.
REQ-038 Count=5, Clear with Push+Pop high -> WE=0, OE=0, next edge Count=0, AddrWrite=AddrRead=0, flags 0.
REQ-039 With FIFO_CONTROL_ALMOST_EN, defaults: Count 2 -> AlmostEmpty=1; Count 3 -> both 0; Count 6 -> AlmostFull=1.

Source files
------------

// File: rtl/fifo_control_if.sv
// Handshake and status bundle between fifo_control and its producer/consumer.
// AlmostFull/AlmostEmpty exist only when FIFO_CONTROL_ALMOST_EN is defined.
interface fifo_control_if;
  logic       Push;
  logic       Pop;
  logic       Clear;
  logic [2:0] AddrWrite;
  logic [2:0] AddrRead;
  logic       WE;
  logic       OE;
  logic [3:0] Count;
  logic       Full;
  logic       Empty;
  logic       Overflow;
  logic       Underflow;
`ifdef FIFO_CONTROL_ALMOST_EN
  logic       AlmostFull;
  logic       AlmostEmpty;

  modport master (
    output Push, Pop, Clear,
    input  AddrWrite, AddrRead, WE, OE, Count, Full, Empty, Overflow, Underflow,
    input  AlmostFull, AlmostEmpty
  );
  modport slave (
    input  Push, Pop, Clear,
    output AddrWrite, AddrRead, WE, OE, Count, Full, Empty, Overflow, Underflow,
    output AlmostFull, AlmostEmpty
  );
`else
  modport master (
    output Push, Pop, Clear,
    input  AddrWrite, AddrRead, WE, OE, Count, Full, Empty, Overflow, Underflow
  );
  modport slave (
    input  Push, Pop, Clear,
    output AddrWrite, AddrRead, WE, OE, Count, Full, Empty, Overflow, Underflow
  );
`endif
endinterface

// File: rtl/fifo_control.sv
// Pointer/occupancy controller for an external 8x16 FIFO memory.
// Optional threshold flags enabled by defining FIFO_CONTROL_ALMOST_EN.
module fifo_control #(
  parameter int unsigned AF_LEVEL = 6,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic          Clk,
  input  logic          Reset,
  fifo_control_if.slave bus
);

  logic [3:0] wr_ptr;
  logic [3:0] rd_ptr;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;
  logic       full;
  logic       empty;
  logic       we;
  logic       oe;

  if (AF_LEVEL < 1 || AF_LEVEL > 7 || AE_LEVEL < 1 || AE_LEVEL > 7) begin : g_level_check
    $error("fifo_control: AF_LEVEL and AE_LEVEL must be within 1..7");
  end

  assign full  = (count == 4'd8);
  assign empty = (count == 4'd0);

  // Reset gating keeps the memory strobes quiet while the async reset is held.
  always_comb begin
    we = bus.Push & (~full | bus.Pop) & ~bus.Clear & ~Reset;
    oe = bus.Pop & ~empty & ~bus.Clear & ~Reset;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (bus.Clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (we) wr_ptr <= wr_ptr + 4'd1;
      if (oe) rd_ptr <= rd_ptr + 4'd1;
      case ({we, oe})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
      if (bus.Push & full & ~bus.Pop) overflow  <= 1'b1;
      if (bus.Pop & empty)            underflow <= 1'b1;
    end
  end

  assign bus.AddrWrite = wr_ptr[2:0];
  assign bus.AddrRead  = rd_ptr[2:0];
  assign bus.WE        = we;
  assign bus.OE        = oe;
  assign bus.Count     = count;
  assign bus.Full      = full;
  assign bus.Empty     = empty;
  assign bus.Overflow  = overflow;
  assign bus.Underflow = underflow;

`ifdef FIFO_CONTROL_ALMOST_EN
  localparam logic [3:0] AF_THRESH = 4'(AF_LEVEL);
  localparam logic [3:0] AE_THRESH = 4'(AE_LEVEL);

  assign bus.AlmostFull  = (count >= AF_THRESH);
  assign bus.AlmostEmpty = (count <= AE_THRESH);
`endif

endmodule

// File: tb/tb_fifo_control.sv
// Self-checking bench for fifo_control: vector table plus hand sequences,
// with a memory model and data-order scoreboard.
module tb_fifo_control;

  logic Clk;
  logic Reset;

  fifo_control_if bus();

  fifo_control #(.AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic       push;
    logic       pop;
    logic       clear;
    logic       we;     // expected before the edge
    logic       oe;
    logic [2:0] aw;
    logic [2:0] ar;
    logic [3:0] count;  // expected after the edge
    logic       full;
    logic       empty;
    logic       ovf;
    logic       unf;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] mem[8];
  logic [15:0] sb[$];
  logic [15:0] wdata;
  int          tests;
  int          failed;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input vec_t v);
    bus.Push  = v.push;
    bus.Pop   = v.pop;
    bus.Clear = v.clear;
    #1;
    check("WE", {15'd0, bus.WE}, {15'd0, v.we});
    check("OE", {15'd0, bus.OE}, {15'd0, v.oe});
    check("AddrWrite", {13'd0, bus.AddrWrite}, {13'd0, v.aw});
    check("AddrRead", {13'd0, bus.AddrRead}, {13'd0, v.ar});
    if (bus.OE) begin
      if (sb.size() == 0) check("sb_underrun", 16'd1, 16'd0);
      else check("read_data", mem[bus.AddrRead], sb.pop_front());
    end
    if (bus.WE) begin
      mem[bus.AddrWrite] = wdata;
      sb.push_back(wdata);
      wdata = wdata + 16'h0101;
    end
    @(posedge Clk);
    #1;
    if (v.clear) sb.delete();
    check("Count", {12'd0, bus.Count}, {12'd0, v.count});
    check("Full", {15'd0, bus.Full}, {15'd0, v.full});
    check("Empty", {15'd0, bus.Empty}, {15'd0, v.empty});
    check("Overflow", {15'd0, bus.Overflow}, {15'd0, v.ovf});
    check("Underflow", {15'd0, bus.Underflow}, {15'd0, v.unf});
`ifdef FIFO_CONTROL_ALMOST_EN
    check("AlmostFull", {15'd0, bus.AlmostFull}, {15'd0, v.count >= 4'd6});
    check("AlmostEmpty", {15'd0, bus.AlmostEmpty}, {15'd0, v.count <= 4'd2});
`endif
    @(negedge Clk);
  endtask

  // Asserts reset between edges with Push/Pop high; returns at a falling edge.
  task automatic do_reset();
    bus.Push  = 1'b1;
    bus.Pop   = 1'b1;
    bus.Clear = 1'b0;
    Reset     = 1'b1;
    #1;
    check("rst_Count", {12'd0, bus.Count}, 16'd0);
    check("rst_AddrWrite", {13'd0, bus.AddrWrite}, 16'd0);
    check("rst_AddrRead", {13'd0, bus.AddrRead}, 16'd0);
    check("rst_Empty", {15'd0, bus.Empty}, 16'd1);
    check("rst_Full", {15'd0, bus.Full}, 16'd0);
    check("rst_WE", {15'd0, bus.WE}, 16'd0);
    check("rst_OE", {15'd0, bus.OE}, 16'd0);
    check("rst_Overflow", {15'd0, bus.Overflow}, 16'd0);
    check("rst_Underflow", {15'd0, bus.Underflow}, 16'd0);
`ifdef FIFO_CONTROL_ALMOST_EN
    check("rst_AlmostEmpty", {15'd0, bus.AlmostEmpty}, 16'd1);
    check("rst_AlmostFull", {15'd0, bus.AlmostFull}, 16'd0);
`endif
    @(posedge Clk);
    #1;
    check("rst_hold_Count", {12'd0, bus.Count}, 16'd0);
    @(negedge Clk);
    Reset     = 1'b0;
    bus.Push  = 1'b0;
    bus.Pop   = 1'b0;
    sb.delete();
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    wdata  = 16'hA001;
    Reset  = 1'b1;
    bus.Push  = 1'b0;
    bus.Pop   = 1'b0;
    bus.Clear = 1'b0;

    // Fill 8, overflow, full push+pop, clear, underflow, no-bypass, clear at 5, drain.
    for (int i = 0; i < 8; i++)
      vecs.push_back('{1, 0, 0, 1, 0, 3'(i), 3'd0, 4'(i + 1), (i == 7), 0, 0, 0});
    vecs.push_back('{1, 0, 0, 0, 0, 3'd0, 3'd0, 4'd8, 1, 0, 1, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 3'd0, 3'd0, 4'd8, 1, 0, 1, 0});
    vecs.push_back('{1, 1, 0, 1, 1, 3'd0, 3'd0, 4'd8, 1, 0, 1, 0});
    vecs.push_back('{1, 1, 1, 0, 0, 3'd1, 3'd1, 4'd0, 0, 1, 0, 0});
    vecs.push_back('{0, 1, 0, 0, 0, 3'd0, 3'd0, 4'd0, 0, 1, 0, 1});
    vecs.push_back('{1, 1, 0, 1, 0, 3'd0, 3'd0, 4'd1, 0, 0, 0, 1});
    for (int k = 1; k <= 4; k++)
      vecs.push_back('{1, 0, 0, 1, 0, 3'(k), 3'd0, 4'(k + 1), 0, 0, 0, 1});
    vecs.push_back('{1, 1, 1, 0, 0, 3'd5, 3'd0, 4'd0, 0, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 3'd0, 3'd0, 4'd0, 0, 1, 0, 0});
    for (int k = 0; k < 3; k++)
      vecs.push_back('{1, 0, 0, 1, 0, 3'(k), 3'd0, 4'(k + 1), 0, 0, 0, 0});
    for (int k = 0; k < 3; k++)
      vecs.push_back('{0, 1, 0, 0, 1, 3'd3, 3'(k), 4'(2 - k), 0, (k == 2), 0, 0});
    vecs.push_back('{0, 1, 0, 0, 0, 3'd3, 3'd3, 4'd0, 0, 1, 0, 1});

    #1;
    @(negedge Clk);
    do_reset();
    foreach (vecs[i]) step(vecs[i]);

    // Reset mid-operation discards occupancy; next push lands at address 0.
    do_reset();
    step('{1, 0, 0, 1, 0, 3'd0, 3'd0, 4'd1, 0, 0, 0, 0});
    step('{1, 0, 0, 1, 0, 3'd1, 3'd0, 4'd2, 0, 0, 0, 0});
    step('{1, 0, 0, 1, 0, 3'd2, 3'd0, 4'd3, 0, 0, 0, 0});
    do_reset();
    step('{1, 0, 0, 1, 0, 3'd0, 3'd0, 4'd1, 0, 0, 0, 0});

    // Fill, then 20 push+pop cycles through the 15->0 pointer wrap, then drain.
    do_reset();
    for (int i = 0; i < 8; i++)
      step('{1, 0, 0, 1, 0, 3'(i), 3'd0, 4'(i + 1), (i == 7), 0, 0, 0});
    for (int j = 0; j < 20; j++)
      step('{1, 1, 0, 1, 1, 3'(j % 8), 3'(j % 8), 4'd8, 1, 0, 0, 0});
    step('{0, 0, 0, 0, 0, 3'd4, 3'd4, 4'd8, 1, 0, 0, 0});
    for (int k = 0; k < 8; k++)
      step('{0, 1, 0, 0, 1, 3'd4, 3'((4 + k) % 8), 4'(7 - k), 0, (k == 7), 0, 0});
    check("sb_drained", 16'(sb.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
